// File: rtl/acq_trigger_sequencer_if.sv
// Sample stream in, DMA capture enable and trigger address out.
// Master drives samples; slave is the trigger sequencer.
interface acq_trigger_sequencer_if #(
   parameter int DATA_WIDTH = 16,
   parameter int ADDR_WIDTH = 32
);
   logic                         in_data_valid;
   logic signed [DATA_WIDTH-1:0] in_data;
   logic [ADDR_WIDTH-1:0]        in_addr;
   logic                         capture_en;
   logic [ADDR_WIDTH-1:0]        trig_addr;

   modport master (
      output in_data_valid,
      output in_data,
      output in_addr,
      input  capture_en,
      input  trig_addr
   );

   modport slave (
      input  in_data_valid,
      input  in_data,
      input  in_addr,
      output capture_en,
      output trig_addr
   );
endinterface

// File: rtl/acq_trigger_sequencer.sv
// Level-trigger acquisition sequencer: pretrig, armed, posttrig, done.
// Define TRIG_HOLDOFF_EN to add a re-arm holdoff input and state.
module acq_trigger_sequencer #(
   parameter int DATA_WIDTH = 16,
   parameter int ADDR_WIDTH = 32,
   parameter int CNT_WIDTH  = 16,
   parameter int HYST       = 10
) (
   input  logic                         clk,
   input  logic                         rst,
   input  logic                         start,
   input  logic                         stop,
   input  logic [1:0]                   mode,
   input  logic                         edge_sel,
   input  logic signed [DATA_WIDTH-1:0] trigger_level,
   input  logic [CNT_WIDTH-1:0]         pre_samples,
   input  logic [CNT_WIDTH-1:0]         post_samples,
   input  logic [CNT_WIDTH-1:0]         auto_timeout,
`ifdef TRIG_HOLDOFF_EN
   input  logic [CNT_WIDTH-1:0]         holdoff,
`endif
   acq_trigger_sequencer_if.slave       bus,
   output logic                         busy,
   output logic                         triggered,
   output logic                         forced,
   output logic                         done,
   output logic [2:0]                   state
);

   typedef enum logic [2:0] {
      IDLE     = 3'd0,
      PRETRIG  = 3'd1,
      ARMED    = 3'd2,
      POSTTRIG = 3'd3,
      DONE     = 3'd4
`ifdef TRIG_HOLDOFF_EN
      , HOLDOFF = 3'd5
`endif
   } state_e;

   localparam logic [CNT_WIDTH-1:0] ONE =
      CNT_WIDTH'(1);
   localparam logic signed [DATA_WIDTH:0] HYST_X =
      (DATA_WIDTH+1)'(HYST);

   state_e cur;
   state_e nxt;

   logic [1:0]                   mode_q;
   logic                         edge_q;
   logic signed [DATA_WIDTH-1:0] level_q;
   logic [CNT_WIDTH-1:0]         pre_q;
   logic [CNT_WIDTH-1:0]         post_q;
   logic [CNT_WIDTH-1:0]         to_q;

   logic [CNT_WIDTH-1:0] pre_cnt;
   logic [CNT_WIDTH-1:0] post_cnt;
   logic [CNT_WIDTH-1:0] to_cnt;
   logic [CNT_WIDTH-1:0] pre_inc;
   logic [CNT_WIDTH-1:0] post_inc;
   logic [CNT_WIDTH-1:0] to_inc;

`ifdef TRIG_HOLDOFF_EN
   logic [CNT_WIDTH-1:0] hold_q;
   logic [CNT_WIDTH-1:0] hold_cnt;
   logic [CNT_WIDTH-1:0] hold_inc;
   logic                 hold_hit;
`endif

   logic                  arm;
   logic [ADDR_WIDTH-1:0] trig_addr_q;

   logic vld;
   logic accept;
   logic is_auto;
   logic rearm;
   logic arm_hit;
   logic lvl_hit;
   logic to_hit;
   logic trig;
   logic pre_hit;
   logic post_hit;

   // One extra bit so level +/- HYST never wraps
   logic signed [DATA_WIDTH:0] smp_x;
   logic signed [DATA_WIDTH:0] lvl_x;
   logic signed [DATA_WIDTH:0] lo_thr;
   logic signed [DATA_WIDTH:0] hi_thr;

   assign smp_x  = {bus.in_data[DATA_WIDTH-1],
                    bus.in_data};
   assign lvl_x  = {level_q[DATA_WIDTH-1], level_q};
   assign lo_thr = lvl_x - HYST_X;
   assign hi_thr = lvl_x + HYST_X;

   assign vld     = bus.in_data_valid;
   assign accept  = (cur == IDLE) && start && !stop;
   assign is_auto = (mode_q == 2'd2);
   assign rearm   = (mode_q == 2'd1) || is_auto;

   assign pre_inc  = pre_cnt + ONE;
   assign post_inc = post_cnt + ONE;
   assign to_inc   = to_cnt + ONE;

   assign arm_hit = edge_q ? (smp_x > hi_thr)
                           : (smp_x < lo_thr);
   assign lvl_hit = arm &&
                    (edge_q ? (smp_x <= lvl_x)
                            : (smp_x >= lvl_x));
   assign to_hit  = is_auto && (to_q != '0) &&
                    (to_inc == to_q);
   assign trig    = (cur == ARMED) && vld &&
                    (lvl_hit || to_hit);

   assign pre_hit  = (pre_q == '0) ||
                     (vld && (pre_inc == pre_q));
   assign post_hit = (post_q == '0) ||
                     (vld && (post_inc == post_q));

`ifdef TRIG_HOLDOFF_EN
   assign hold_inc = hold_cnt + ONE;
   assign hold_hit = vld && (hold_inc == hold_q);
`endif

   always_ff @(posedge clk) begin
      if (rst) cur <= IDLE;
      else     cur <= nxt;
   end

   always_comb begin
      nxt = cur;
      case (cur)
         IDLE:     if (accept)   nxt = PRETRIG;
         PRETRIG:  if (pre_hit)  nxt = ARMED;
         ARMED:    if (trig)     nxt = POSTTRIG;
         POSTTRIG: if (post_hit) nxt = DONE;
         DONE: begin
            nxt = IDLE;
            if (rearm) nxt = PRETRIG;
`ifdef TRIG_HOLDOFF_EN
            if (rearm && hold_q != '0)
               nxt = HOLDOFF;
`endif
         end
`ifdef TRIG_HOLDOFF_EN
         HOLDOFF:  if (hold_hit) nxt = PRETRIG;
`endif
         default:  nxt = IDLE;
      endcase
      if (stop) nxt = IDLE;
   end

   always_ff @(posedge clk) begin
      if (rst) begin
         mode_q      <= '0;
         edge_q      <= 1'b0;
         level_q     <= '0;
         pre_q       <= '0;
         post_q      <= '0;
         to_q        <= '0;
         pre_cnt     <= '0;
         post_cnt    <= '0;
         to_cnt      <= '0;
         arm         <= 1'b0;
         trig_addr_q <= '0;
         triggered   <= 1'b0;
         forced      <= 1'b0;
`ifdef TRIG_HOLDOFF_EN
         hold_q      <= '0;
         hold_cnt    <= '0;
`endif
      end else begin
         triggered <= 1'b0;
         if (accept) begin
            mode_q  <= mode;
            edge_q  <= edge_sel;
            level_q <= trigger_level;
            pre_q   <= pre_samples;
            post_q  <= post_samples;
            to_q    <= auto_timeout;
            forced  <= 1'b0;
`ifdef TRIG_HOLDOFF_EN
            hold_q  <= holdoff;
`endif
         end
         // Every state change starts the counters afresh
         if (nxt != cur) begin
            pre_cnt  <= '0;
            post_cnt <= '0;
            to_cnt   <= '0;
            arm      <= 1'b0;
`ifdef TRIG_HOLDOFF_EN
            hold_cnt <= '0;
`endif
         end else if (vld) begin
            unique case (1'b1)
               (cur == PRETRIG):
                  pre_cnt <= pre_inc;
               (cur == ARMED): begin
                  to_cnt <= to_inc;
                  if (arm_hit) arm <= 1'b1;
               end
               (cur == POSTTRIG):
                  post_cnt <= post_inc;
`ifdef TRIG_HOLDOFF_EN
               (cur == HOLDOFF):
                  hold_cnt <= hold_inc;
`endif
               default: ;
            endcase
         end
         if (trig && !stop) begin
            trig_addr_q <= bus.in_addr;
            triggered   <= 1'b1;
            forced      <= to_hit && !lvl_hit;
         end
      end
   end

   assign bus.capture_en = (cur == PRETRIG) ||
                           (cur == ARMED) ||
                           (cur == POSTTRIG);
   assign bus.trig_addr  = trig_addr_q;
   assign busy           = (cur != IDLE);
   assign done           = (cur == DONE);
   assign state          = cur;

endmodule

// File: tb/tb_acq_trigger_sequencer.sv
// Scoreboard bench for acq_trigger_sequencer.
// Stimulus queues expected trigger/done events; a monitor checks them.
module tb_acq_trigger_sequencer;

   logic        clk = 1'b0;
   logic        rst;
   logic        start;
   logic        stop;
   logic [1:0]  mode;
   logic        edge_sel;
   logic signed [15:0] trigger_level;
   logic [15:0] pre_samples;
   logic [15:0] post_samples;
   logic [15:0] auto_timeout;
`ifdef TRIG_HOLDOFF_EN
   logic [15:0] holdoff = '0;
`endif
   logic        busy;
   logic        triggered;
   logic        forced;
   logic        done;
   logic [2:0]  dut_state;

   acq_trigger_sequencer_if #(
      .DATA_WIDTH(16), .ADDR_WIDTH(32)) bus ();

   acq_trigger_sequencer dut (
      .clk           (clk),
      .rst           (rst),
      .start         (start),
      .stop          (stop),
      .mode          (mode),
      .edge_sel      (edge_sel),
      .trigger_level (trigger_level),
      .pre_samples   (pre_samples),
      .post_samples  (post_samples),
      .auto_timeout  (auto_timeout),
`ifdef TRIG_HOLDOFF_EN
      .holdoff       (holdoff),
`endif
      .bus           (bus),
      .busy          (busy),
      .triggered     (triggered),
      .forced        (forced),
      .done          (done),
      .state         (dut_state)
   );

   always #5 clk = ~clk;

   typedef struct packed {
      logic [31:0] addr;
      logic        frc;
   } trig_t;

   trig_t trig_q[$];
   int    done_q[$];
   int    n_cmp = 0;
   int    n_bad = 0;
   logic [31:0] cur_addr = 32'h1000;
   logic [31:0] b_addr;

   task automatic chk(input string nm,
                      input logic [63:0] act,
                      input logic [63:0] exp);
      n_cmp++;
      if (act !== exp) begin
         n_bad++;
         $display("FAIL %s: got %0h want %0h",
                  nm, act, exp);
      end
   endtask

   task automatic step(input bit v, input int d,
                       input int es,
                       input bit st = 1'b0,
                       input bit sp = 1'b0);
      @(negedge clk);
      if (es >= 0) chk("state", 64'(dut_state), 64'(es));
      start = st;
      stop  = sp;
      bus.in_data_valid = v;
      bus.in_data = d[15:0];
      cur_addr = cur_addr + 32'd4;
      bus.in_addr = cur_addr;
   endtask

   task automatic cfg(input int m, input int e,
                      input int lvl, input int pre,
                      input int post, input int to);
      mode          = m[1:0];
      edge_sel      = e[0];
      trigger_level = lvl[15:0];
      pre_samples   = pre[15:0];
      post_samples  = post[15:0];
      auto_timeout  = to[15:0];
   endtask

   task automatic exp_ev(input bit frc);
      trig_q.push_back('{cur_addr, frc});
      done_q.push_back(1);
   endtask

   always @(negedge clk) begin
      if (!rst) begin
         if (triggered) begin
            if (trig_q.size() == 0) begin
               chk("trig_unexp", 64'(triggered), 64'd0);
            end else begin
               trig_t e;
               e = trig_q.pop_front();
               chk("trig_addr", 64'(bus.trig_addr),
                   64'(e.addr));
               chk("forced", 64'(forced), 64'(e.frc));
               chk("trig_state", 64'(dut_state), 64'd3);
            end
         end
         if (done) begin
            if (done_q.size() == 0) begin
               chk("done_unexp", 64'(done), 64'd0);
            end else begin
               void'(done_q.pop_front());
               chk("done_cap", 64'(bus.capture_en), 64'd0);
               chk("done_busy", 64'(busy), 64'd1);
            end
         end
      end
   end

   initial begin
      #200000;
      $display("FAIL watchdog: got timeout want finish");
      $fatal(1, "watchdog");
   end

   initial begin
      rst = 1'b1;
      start = 1'b0;
      stop = 1'b0;
      cfg(0, 0, 0, 0, 0, 0);
      bus.in_data_valid = 1'b0;
      bus.in_data = '0;
      bus.in_addr = '0;
      repeat (3) @(negedge clk);
      chk("rst_state", 64'(dut_state), 64'd0);
      chk("rst_cap", 64'(bus.capture_en), 64'd0);
      chk("rst_busy", 64'(busy), 64'd0);
      chk("rst_taddr", 64'(bus.trig_addr), 64'd0);
      chk("rst_flags", 64'({triggered, forced, done}),
          64'd0);
      rst = 1'b0;

      // single rising ramp, inputs churned mid-run
      cfg(0, 0, 100, 4, 3, 0);
      step(0, 0, 0, 1'b1);
      for (int i = 0; i < 26; i++) begin
         int es;
         es = (i < 4) ? 1 : (i <= 15) ? 2 :
              (i <= 18) ? 3 : (i == 19) ? 4 : 0;
         step(1'b1, -50 + 10 * i, es, (i == 8));
         if (i == 1) cfg(1, 1, -1000, 1, 1, 1);
         if (i == 10)
            chk("cap_armed", 64'(bus.capture_en), 64'd1);
         if (i == 15) exp_ev(1'b0);
      end
      chk("cap_idle", 64'(bus.capture_en), 64'd0);

      // rising at 0: -10 must not arm, -20 does
      cfg(0, 0, 0, 0, 2, 0);
      step(0, 0, 0, 1'b1);
      step(0, 0, 1);
      step(1, 50, 2); step(1, 50, 2); step(1, 50, 2);
      step(1, -10, 2); step(1, 50, 2);
      step(1, -20, 2); step(1, 5, 2); exp_ev(1'b0);
      step(1, 7, 3); step(1, 9, 3);
      step(0, 0, 4); step(0, 0, 0);

      // falling at the minimum level
      cfg(0, 1, -32768, 0, 1, 0);
      step(0, 0, 0, 1'b1);
      step(0, 0, 1);
      step(1, -32768, 2); step(1, -32758, 2);
      step(1, -32768, 2); step(1, -32757, 2);
      step(1, -32768, 2); exp_ev(1'b0);
      step(1, 0, 3); step(0, 0, 4); step(0, 0, 0);

      // rising at the minimum level can never arm
      cfg(0, 0, -32768, 0, 0, 0);
      step(0, 0, 0, 1'b1);
      step(0, 0, 1);
      step(1, 0, 2); step(1, -32768, 2); step(1, 100, 2);
      step(0, 0, 2, 1'b0, 1'b1);
      step(0, 0, 0);

      // auto mode: two forced triggers, then stop
      cfg(2, 0, 1000, 0, 0, 8);
      step(0, 0, 0, 1'b1);
      step(0, 0, 1);
      for (int k = 0; k < 8; k++) step(1, 0, 2);
      exp_ev(1'b1);
      step(0, 0, 3); step(0, 0, 4); step(0, 0, 1);
      for (int k = 0; k < 8; k++) step(1, 0, 2);
      exp_ev(1'b1);
      step(0, 0, 3); step(0, 0, 4);
      step(0, 0, 1, 1'b0, 1'b1);
      step(0, 0, 0);

      // normal mode with the same input never fires
      cfg(1, 0, 1000, 0, 0, 8);
      step(0, 0, 0, 1'b1);
      step(0, 0, 1);
      chk("forced_clr", 64'(forced), 64'd0);
      for (int k = 0; k < 20; k++) step(1, 0, 2);
      step(0, 0, 2, 1'b0, 1'b1);
      step(0, 0, 0);

      // normal mode: two crossings, stop on the third
      cfg(1, 0, 100, 0, 1, 0);
      step(0, 0, 0, 1'b1);
      step(0, 0, 1);
      step(1, 0, 2); step(1, 150, 2); exp_ev(1'b0);
      step(1, 150, 3); step(0, 0, 4); step(0, 0, 1);
      step(1, 0, 2); step(1, 150, 2); exp_ev(1'b0);
      b_addr = cur_addr;
      step(1, 150, 3); step(0, 0, 4); step(0, 0, 1);
      step(0, 0, 2); step(1, 0, 2);
      step(1, 150, 2, 1'b0, 1'b1);
      step(0, 0, 0);
      chk("addr_hold", 64'(bus.trig_addr), 64'(b_addr));

      // gapped valid, pre=0 post=0
      cfg(0, 0, 0, 0, 0, 0);
      step(0, 0, 0, 1'b1);
      step(0, 50, 1);
      step(1, -20, 2); step(0, 50, 2); step(0, 50, 2);
      step(1, 5, 2); exp_ev(1'b0);
      step(0, 50, 3); step(0, 50, 4); step(0, 50, 0);

      // gapped valid, pre=2 post=2
      cfg(0, 0, 0, 2, 2, 0);
      step(0, 0, 0, 1'b1);
      step(1, -20, 1); step(0, 50, 1); step(0, 50, 1);
      step(1, -20, 1); step(0, 50, 2); step(0, 50, 2);
      step(1, -20, 2); step(0, 50, 2);
      step(1, 5, 2); exp_ev(1'b0);
      step(0, 50, 3); step(1, 7, 3); step(0, 50, 3);
      step(0, 50, 3); step(1, 7, 3);
      step(0, 0, 4); step(0, 0, 0);

      // start+stop together stays idle
      step(0, 0, 0, 1'b1, 1'b1);
      step(0, 0, 0);

      // reset in the middle of an acquisition
      cfg(0, 0, 100, 0, 0, 0);
      step(0, 0, 0, 1'b1);
      step(1, 0, 1);
      step(1, 0, 2);
      @(negedge clk);
      rst = 1'b1;
      bus.in_data_valid = 1'b0;
      @(negedge clk);
      chk("mid_rst_state", 64'(dut_state), 64'd0);
      chk("mid_rst_cap", 64'(bus.capture_en), 64'd0);
      chk("mid_rst_busy", 64'(busy), 64'd0);
      rst = 1'b0;
      step(0, 0, 0);
      step(0, 0, 0);

      chk("trig_left", 64'(trig_q.size()), 64'd0);
      chk("done_left", 64'(done_q.size()), 64'd0);
      $display("*** SUMMARY: %0d compared / %0d mismatched ***",
               n_cmp, n_bad);
      $finish;
   end

endmodule

// File: doc/acq_trigger_sequencer.md
Name: acq_trigger_sequencer

Overview:
- Sequences one acquisition around a level trigger: pre-trigger fill, armed wait with hysteresis, post-trigger count, done.
- Sits between the sample stream/DMA address counter and the capture/DMA enable.
- Tells the host where in the DMA buffer the trigger occurred.
- Supports single, normal (re-arm) and auto (timeout-forced) modes.

Parameters:
- DATA_WIDTH, 16, sample width (signed two's complement).
- ADDR_WIDTH, 32, DMA master address width.
- CNT_WIDTH, 16, width of the pre/post/timeout sample counters.
- HYST, 10, re-arm hysteresis in LSBs.

Ports:
- clk, in, 1, clock.
- rst, in, 1, reset; synchronous, active-high.
- start, in, 1, one-cycle request to begin an acquisition.
- stop, in, 1, one-cycle abort.
- mode, in, 2, 0=single, 1=normal, 2=auto, 3=treated as single.
- edge_sel, in, 1, 0=rising, 1=falling.
- trigger_level, in, DATA_WIDTH, signed trigger level.
- pre_samples, in, CNT_WIDTH, valid samples to capture before arming.
- post_samples, in, CNT_WIDTH, valid samples to capture after the trigger sample.
- auto_timeout, in, CNT_WIDTH, armed valid samples before a forced trigger (auto mode only).
- in_data_valid, in, 1, sample strobe.
- in_data, in, DATA_WIDTH, signed sample.
- in_addr, in, ADDR_WIDTH, DMA address of the current sample.
- capture_en, out, 1, DMA capture enable.
- busy, out, 1, high whenever state is not IDLE.
- triggered, out, 1, one-cycle pulse on the trigger.
- forced, out, 1, set with triggered if the trigger came from timeout; cleared at next start.
- done, out, 1, one-cycle pulse when the post count completes.
- trig_addr, out, ADDR_WIDTH, in_addr of the triggering sample.
- state, out, 3, current state encoding.

Behaviour:
- Reset values: all outputs 0; state IDLE; counters 0; arm flag 0.
- States: IDLE=0, PRETRIG=1, ARMED=2, POSTTRIG=3, DONE=4. All transitions are registered, one cycle each.
- Config latch: on accepted start, shadow-register mode, edge_sel, trigger_level, pre_samples, post_samples and auto_timeout. Input changes mid-acquisition have no effect.
- IDLE:
  - capture_en=0.
  - start -> PRETRIG; clear counters and forced.
  - start outside IDLE is ignored.
- PRETRIG:
  - capture_en=1.
  - pre_cnt increments per valid sample.
  - -> ARMED on the cycle the valid sample makes pre_cnt==pre_samples.
  - pre_samples==0 -> ARMED on the next cycle with no sample needed.
- ARMED:
  - capture_en=1; arm flag cleared on entry.
  - Compares use DATA_WIDTH+1-bit signed arithmetic, so level±HYST never wraps.
  - Rising: arm flag set on a valid sample < level-HYST. Trigger on a valid sample >= level while the arm flag is set.
  - Falling: arm flag set on a valid sample > level+HYST. Trigger on a valid sample <= level while the arm flag is set.
  - Arm and trigger on the same sample is impossible; the arm flag is registered.
  - Auto mode: to_cnt counts valid samples in ARMED. The valid sample making to_cnt==auto_timeout forces a trigger (forced=1). auto_timeout==0 means no timeout.
  - On trigger: trig_addr<=in_addr, triggered=1 for one cycle, -> POSTTRIG.
- POSTTRIG:
  - capture_en=1.
  - post_cnt counts valid samples after the trigger sample.
  - -> DONE when post_cnt==post_samples; post_samples==0 -> DONE on the next cycle.
- DONE:
  - One cycle; done=1, capture_en=0.
  - Single -> IDLE; normal/auto -> PRETRIG with counters cleared. Latched config is reused.
- stop: from any non-IDLE state -> IDLE next cycle with capture_en=0. stop has priority over a trigger or completion in the same cycle; no triggered/done pulse is issued.
- Simultaneous start+stop in IDLE: stop wins, remain IDLE.
- Mid-operation rst returns everything to reset values on that edge.

Optional Feature:
- Macro TRIG_HOLDOFF_EN.
- When defined: adds input holdoff (CNT_WIDTH), latched at start, and state HOLDOFF=5. In normal/auto mode DONE -> HOLDOFF, which counts holdoff valid samples with capture_en=0 and then goes -> PRETRIG. holdoff==0 goes straight to PRETRIG. stop aborts HOLDOFF to IDLE.
- When undefined: no port, no state; DONE -> PRETRIG directly.

Test Plan:
- Single, rising, level=100, pre=4, post=3, ramp -50..200 step 10 on every cycle valid -> ARMED after 4 samples. Arm at <90, trigger at sample 100 with trig_addr = its in_addr. done 3 valid samples later, then IDLE, capture_en=0.
- Rising, level=0, stream starts at 50, no dip below -10 -> no trigger. Dip to -20 then 5 -> trigger on the 5.
- Falling, level=-32768 (minimum) -> threshold math does not wrap. Trigger on sample -32768 after seeing >-32758.
- Auto, auto_timeout=8, flat input 0 with level 1000 -> forced trigger on the 8th armed valid sample, forced=1. Normal-mode variant never triggers.
- Normal mode, two crossings -> two done pulses with distinct trig_addr. Stop asserted on the trigger cycle -> IDLE, no triggered pulse.
- in_data_valid gapped (1 of 3 cycles), pre=0, post=0 -> counting only on valid samples. ARMED on the cycle after start-accept; DONE on the cycle after trigger.
